// File: rtl/sms_pkg.sv
// Shared definitions for the SMS trigger driver slice.
//   - command encodings carried on the 2-bit cmd bus
//   - sequencer state type
//   - trigger side type (left drives the trigger to 0, right drives it to 1)
//   - phase_load(): counter preload for an N-cycle phase
package sms_pkg;

  localparam logic [1:0] CMD_NOP        = 2'b00;
  localparam logic [1:0] CMD_SET        = 2'b01;
  localparam logic [1:0] CMD_RESET      = 2'b10;
  localparam logic [1:0] CMD_COMPLEMENT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_t;

  // The phase counter reports terminal count at zero, so an N-cycle phase
  // is loaded with N-1.
  function automatic logic [2:0] phase_load(input int unsigned n);
    return 3'(n - 1);
  endfunction

endpackage

// File: rtl/sms_phase_counter.sv
// 3-bit down-counter used to time the SETUP, PULSE and HOLD phases.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count clears to 0)
//   load      load load_val this edge (has priority over counting)
//   load_val  preload value
//   tc        terminal count: high while the count is 0
module sms_phase_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       tc
);

  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/sms_trigger_driver.sv
// Driver card logic for one SDTRL trigger binary. Converts set / reset /
// complement level commands into a conditioning-gate level plus an AC-set
// pulse on the selected side, then reads the trigger back.
//
// Optional feature macro: SMS_TRIGGER_DRIVER_VERIFY_EN
//   defined   -> CHECK compares trig_b against the expected value and flags
//                an invalid trigger (trig_b == trig_p) on err
//   undefined -> CHECK still occupies one cycle, err is tied 0, trig_p unused
//
// Ports:
//   x           system clock, rising edge
//   reset_n     asynchronous active-low reset
//   cmd_valid   command request
//   cmd         00 nop, 01 set, 10 reset, 11 complement
//   cmd_ready   high in IDLE only
//   trig_b      trigger true output
//   trig_p      trigger complement output
//   gate_left   left conditioning gate (drives trigger to 0)
//   ac_left     left AC-set pulse
//   gate_right  right conditioning gate (drives trigger to 1)
//   ac_right    right AC-set pulse
//   done        one-cycle completion pulse
//   err         one-cycle readback-mismatch pulse, coincident with done
module sms_trigger_driver
  import sms_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       x,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       trig_b,
  input  logic       trig_p,
  output logic       gate_left,
  output logic       ac_left,
  output logic       gate_right,
  output logic       ac_right,
  output logic       done,
  output logic       err
);

  state_t     state_q, state_d;
  side_t      side_q, side_d;
  logic       nop_done_q;
  logic       accept;
  logic       cnt_load;
  logic [2:0] cnt_load_val;
  logic       cnt_tc;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  sms_phase_counter u_phase_cnt (
    .clk      (x),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tc       (cnt_tc)
  );

  // State register; the side is latched only on a non-nop accept, so later
  // trig_b movement cannot redirect a complement in flight.
  always_ff @(posedge x or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      side_q     <= SIDE_LEFT;
      nop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      side_q     <= side_d;
      nop_done_q <= accept && (cmd == CMD_NOP);
    end
  end

  // Next-state and phase-counter control. Each phase preloads the counter
  // on its entry edge; tc marks the last cycle of the phase.
  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && (cmd != CMD_NOP)) begin
          state_d      = ST_SETUP;
          cnt_load     = 1'b1;
          cnt_load_val = phase_load(SETUP_CYC);
          unique case (cmd)
            CMD_SET:   side_d = SIDE_RIGHT;
            CMD_RESET: side_d = SIDE_LEFT;
            default:   side_d = trig_b ? SIDE_LEFT : SIDE_RIGHT;
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt_tc) begin
          state_d      = ST_PULSE;
          cnt_load     = 1'b1;
          cnt_load_val = phase_load(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (cnt_tc) begin
          if (HOLD_CYC != 0) begin
            state_d      = ST_HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = phase_load(HOLD_CYC);
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_tc) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so an async reset drops the
  // gates and AC lines without waiting for a clock edge.
  always_comb begin
    logic gate_on;
    logic ac_on;
    gate_on    = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                 (state_q == ST_HOLD);
    ac_on      = (state_q == ST_PULSE);
    gate_left  = gate_on && (side_q == SIDE_LEFT);
    ac_left    = ac_on   && (side_q == SIDE_LEFT);
    gate_right = gate_on && (side_q == SIDE_RIGHT);
    ac_right   = ac_on   && (side_q == SIDE_RIGHT);
    cmd_ready  = (state_q == ST_IDLE);
    done       = (state_q == ST_CHECK) || nop_done_q;
`ifdef SMS_TRIGGER_DRIVER_VERIFY_EN
    err        = (state_q == ST_CHECK) &&
                 ((trig_b != (side_q == SIDE_RIGHT)) || (trig_b == trig_p));
`else
    err        = 1'b0;
`endif
  end

`ifndef SMS_TRIGGER_DRIVER_VERIFY_EN
  logic unused_trig_p;
  assign unused_trig_p = trig_p;
`endif

endmodule

// File: tb/tb_sms_trigger_driver.sv
module tb_sms_trigger_driver;

`ifdef SMS_TRIGGER_DRIVER_VERIFY_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic x = 1'b0;
  logic reset_n = 1'b1;
  always #5 x = ~x;

  // DUT 1: default timing
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready, trig_b, trig_p;
  logic       gate_left, ac_left, gate_right, ac_right, done, err;

  // DUT 2: SETUP=2, PULSE=3, HOLD=0
  logic       cmd_valid2;
  logic [1:0] cmd2;
  logic       cmd_ready2, trig_b2, trig_p2;
  logic       gate_left2, ac_left2, gate_right2, ac_right2, done2, err2;

  sms_trigger_driver u_dut (
    .x(x), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .trig_b(trig_b), .trig_p(trig_p),
    .gate_left(gate_left), .ac_left(ac_left),
    .gate_right(gate_right), .ac_right(ac_right),
    .done(done), .err(err)
  );

  sms_trigger_driver #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(0)) u_dut2 (
    .x(x), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd(cmd2),
    .cmd_ready(cmd_ready2), .trig_b(trig_b2), .trig_p(trig_p2),
    .gate_left(gate_left2), .ac_left(ac_left2),
    .gate_right(gate_right2), .ac_right(ac_right2),
    .done(done2), .err(err2)
  );

  // Trigger models: capture on an edge where gate and AC of a side are high.
  logic trig_q, preset_en, preset_val, stuck, bad_p;
  logic trig2_q, preset2_en, preset2_val;

  always @(posedge x) begin
    if (preset_en) trig_q <= preset_val;
    else if (!stuck) begin
      if (gate_left && ac_left) trig_q <= 1'b0;
      else if (gate_right && ac_right) trig_q <= 1'b1;
    end
  end
  assign trig_b = trig_q;
  assign trig_p = bad_p ? trig_q : ~trig_q;

  always @(posedge x) begin
    if (preset2_en) trig2_q <= preset2_val;
    else if (gate_left2 && ac_left2) trig2_q <= 1'b0;
    else if (gate_right2 && ac_right2) trig2_q <= 1'b1;
  end
  assign trig_b2 = trig2_q;
  assign trig_p2 = ~trig2_q;

  // Running monitors
  int done_cnt = 0;
  int viol = 0;
  always @(negedge x) begin
    if (done) done_cnt <= done_cnt + 1;
    if ((gate_left && gate_right) || (ac_left && ac_right) ||
        (ac_left && !gate_left) || (ac_right && !gate_right) ||
        (gate_left2 && gate_right2) || (ac_left2 && ac_right2) ||
        (ac_left2 && !gate_left2) || (ac_right2 && !gate_right2))
      viol <= viol + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge x);
    #1;
  endtask

  task automatic preset(input logic v);
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Packed DUT1 view: {gate_left, ac_left, gate_right, ac_right, done, err, cmd_ready}
  function automatic logic [6:0] view1();
    return {gate_left, ac_left, gate_right, ac_right, done, err, cmd_ready};
  endfunction

  // Checks cycles 1..5 of a default-timing sequence; called in cycle 1.
  task automatic seq1(input string tag, input logic right, input logic exp_trig,
                      input logic exp_err);
    chk({tag, "_c1"}, view1(), {!right, 1'b0, right, 1'b0, 3'b000});
    tick();
    chk({tag, "_c2"}, view1(), {!right, !right, right, right, 3'b000});
    tick();
    chk({tag, "_c3"}, view1(), {!right, 1'b0, right, 1'b0, 3'b000});
    chk({tag, "_trig"}, trig_b, exp_trig);
    tick();
    chk({tag, "_c4"}, view1(), {4'b0000, 1'b1, exp_err, 1'b0});
    tick();
    chk({tag, "_c5"}, view1(), 7'b0000001);
  endtask

  initial begin
    int base;
    cmd_valid = 1'b0; cmd = 2'b00; cmd_valid2 = 1'b0; cmd2 = 2'b00;
    preset_en = 1'b0; preset_val = 1'b0; stuck = 1'b0; bad_p = 1'b0;
    preset2_en = 1'b0; preset2_val = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk("reset_outputs", view1(), 7'b0000001);
    @(negedge x) reset_n = 1'b1;
    tick();

    // Reset side from 1
    preset(1'b1);
    issue(2'b10);
    seq1("reset_cmd", 1'b0, 1'b0, 1'b0);

    // Complement from 0 then back
    preset(1'b0);
    issue(2'b11);
    seq1("compl_up", 1'b1, 1'b1, 1'b0);
    issue(2'b11);
    seq1("compl_dn", 1'b0, 1'b0, 1'b0);

    // Nop: done next cycle, nothing else
    issue(2'b00);
    chk("nop_c1", view1(), 7'b0000101);
    tick();
    chk("nop_c2", view1(), 7'b0000001);

    // Trigger gate stuck low
    preset(1'b0);
    stuck = 1'b1;
    issue(2'b01);
    seq1("stuck", 1'b1, 1'b0, ERR_EXP);
    stuck = 1'b0;

    // Invalid trigger: trig_p follows trig_b
    preset(1'b1);
    bad_p = 1'b1;
    issue(2'b10);
    seq1("invalid", 1'b0, 1'b0, ERR_EXP);
    bad_p = 1'b0;

    // Reset during PULSE
    preset(1'b1);
    issue(2'b10);
    tick();
    chk("pre_abort_pulse", view1(), 7'b1100000);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", view1(), 7'b0000001);
    base = done_cnt;
    @(negedge x) reset_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_trig_kept", trig_b, 1'b1);
    issue(2'b10);
    seq1("after_abort", 1'b0, 1'b0, 1'b0);

    // cmd_valid held through busy: accepts at first edge and at the first
    // IDLE edge after completion only
    preset(1'b0);
    base = done_cnt;
    cmd_valid = 1'b1;
    cmd = 2'b01;
    repeat (6) tick();
    cmd_valid = 1'b0;
    repeat (12) tick();
    chk("held_valid_dones", done_cnt - base, 2);
    chk("held_valid_trig", trig_b, 1'b1);

    // DUT2 timing: gate cycles 1-5, ac cycles 3-5, done cycle 6
    preset2_en = 1'b1; preset2_val = 1'b0;
    tick();
    preset2_en = 1'b0;
    cmd_valid2 = 1'b1; cmd2 = 2'b01;
    tick();
    cmd_valid2 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("p2_c%0d", c),
          {gate_left2, ac_left2, gate_right2, ac_right2, done2, err2, cmd_ready2},
          {1'b0, 1'b0, (c <= 5), (c >= 3 && c <= 5), (c == 6), 1'b0, (c >= 7)});
      tick();
    end
    chk("p2_trig", trig_b2, 1'b1);

    chk("no_overlap", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
